// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data load/store, with pipeline stall generation.
// Optional performance counters are compiled in with `define ARB_PERF_CNT_EN.
module mem_port_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_gnt,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_valid,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_if,
  output logic          stall_mem
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [15:0]   conflict_cnt,
  output logic [15:0]   flush_drop_cnt
`endif
);

  localparam int LW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [LW-1:0] LAT_LOAD   = LW'(MEM_LAT);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_t;

  state_t        state;
  logic [LW-1:0] lat_cnt;
  logic [SW-1:0] starve_cnt;
  logic          owner;      // 0 = fetch, 1 = data
  logic          cancel;
  logic          issue;
  logic          pick_if;

  // Gating with rst keeps every strobe quiet while reset is held, even with requests up.
  assign issue   = rst & (state == ST_IDLE) & (if_req | dm_req);
  assign pick_if = if_req & (~dm_req | (starve_cnt == STARVE_TOP));

  assign if_gnt    = issue & pick_if;
  assign dm_gnt    = issue & ~pick_if;
  assign mem_en    = issue;
  assign mem_we    = dm_gnt & dm_we;
  assign mem_addr  = if_gnt ? if_addr : (dm_gnt ? dm_addr : '0);
  assign mem_wdata = dm_gnt ? dm_wdata : '0;

  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = dm_req & ~dm_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      owner      <= 1'b0;
      cancel     <= 1'b0;
      if_valid   <= 1'b0;
      dm_valid   <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (issue) begin
            owner   <= ~pick_if;
            lat_cnt <= LAT_LOAD;
            cancel  <= pick_if & if_flush;
            state   <= ST_BUSY;
            if (pick_if)
              starve_cnt <= '0;
            else if (if_req && starve_cnt != STARVE_TOP)
              starve_cnt <= starve_cnt + 1'b1;
          end
        end
        ST_BUSY: begin
          lat_cnt <= lat_cnt - 1'b1;
          if (!owner && if_flush)
            cancel <= 1'b1;
          if (lat_cnt == LW'(1)) begin
            state <= ST_RESP;
            if (owner) begin
              dm_rdata <= mem_rdata;
              dm_valid <= 1'b1;
            end else begin
              // A flush landing on the capture edge must also drop the delivery.
              if_rdata <= mem_rdata;
              if_valid <= ~(cancel | if_flush);
            end
          end
        end
        ST_RESP: begin
          state  <= ST_IDLE;
          cancel <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_cnt   <= '0;
      flush_drop_cnt <= '0;
    end else begin
      if (issue && if_req && dm_req)
        conflict_cnt <= conflict_cnt + 16'd1;
      if (state == ST_RESP && !owner && cancel)
        flush_drop_cnt <= flush_drop_cnt + 16'd1;
    end
  end
`endif

endmodule
